eq_share_ctrl: RTL and testbench
================================

Name: eq_share_ctrl

Overview:
- Shares one 2-bit equality slice (two 1-bit equality cells ANDed) between two requesters.
- Serially compares WIDTH-bit operand pairs, 2 bits per cycle, LSB chunk first, and stops early on the first mismatching chunk.
- Arbitrates round-robin, holds operands internally, and returns a single-cycle result pulse to the winning requester.

Parameters:
- WIDTH, 8, operand width in bits; must be even and >= 2; CHUNKS = WIDTH/2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operand pair.
- req0_ready  output  1  requester 0 pair accepted this cycle.
- req0_a  input  WIDTH  requester 0 operand A.
- req0_b  input  WIDTH  requester 0 operand B.
- req1_valid  input  1  requester 1 has an operand pair.
- req1_ready  output  1  requester 1 pair accepted this cycle.
- req1_a  input  WIDTH  requester 1 operand A.
- req1_b  input  WIDTH  requester 1 operand B.
- rsp0_valid  output  1  one-cycle result pulse for requester 0.
- rsp0_eq  output  1  1 = operands equal; qualified by rsp0_valid.
- rsp1_valid  output  1  one-cycle result pulse for requester 1.
- rsp1_eq  output  1  1 = operands equal; qualified by rsp1_valid.
- busy  output  1  high in CMP and DONE.
- grant_id  output  1  requester owning the current or last transaction.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE, chunk index=0, result=0, last_grant=1 (so requester 0 wins the first tie).
  - grant_id=0; all rsp*, busy and ready outputs = 0.
  - Operand registers are don't-care.
- States: IDLE, CMP, DONE.
- IDLE, arbitration:
  - Grant is a combinational function of req0_valid, req1_valid and last_grant.
  - Only one requester valid: it wins.
  - Both valid: the one != last_grant wins.
  - reqN_ready = (state==IDLE) & reqN_valid & (winner==N). At most one ready is high; none outside IDLE.
- IDLE, handshake:
  - A transfer is valid & ready in the same cycle.
  - On transfer: capture reqN_a/reqN_b, set grant_id=N, index=0, go to CMP.
  - Requesters hold valid and data until ready. An unaccepted request may change or drop with no effect.
- CMP:
  - Each cycle: eq_chunk = (A[2i+1:2i] == B[2i+1:2i]) for the current index i.
  - eq_chunk=0: result=0, go to DONE.
  - eq_chunk=1 and i==CHUNKS-1: result=1, go to DONE.
  - Otherwise: i increments, stay in CMP.
  - The index never exceeds CHUNKS-1.
- DONE (exactly one cycle):
  - rsp<grant_id>_valid=1 and rsp<grant_id>_eq=result; the other requester's rsp outputs stay 0.
  - last_grant <= grant_id; go to IDLE.
- rsp outputs are registered and decoded from state. rspN_eq=0 whenever rspN_valid=0.
- Latency, with the handshake in cycle T:
  - Full match: rsp_valid in cycle T+CHUNKS+1.
  - First mismatch at chunk j: rsp_valid in cycle T+j+2.
  - The next handshake occurs no earlier than the cycle after DONE, so there are no back-to-back accepts.
- Boundaries:
  - WIDTH=2: one CMP cycle.
  - Requester inputs are ignored while busy.
  - last_grant changes only in DONE, so a single active requester is served repeatedly.
  - Reset mid-CMP or in DONE aborts the transaction: no rsp pulse, return to reset values. The requester must re-issue.

Test Plan:
- WIDTH=8; req0 a=8'hA5, b=8'hA5, req1 idle -> req0_ready in T; busy T+1..T+5; rsp0_valid=1, rsp0_eq=1 in T+5 only; rsp1_valid=0 throughout.
- req1 a=8'h3C, b=8'h3D (chunk 0 mismatch) -> rsp1_valid=1, rsp1_eq=0 in T+2; grant_id=1.
- req1 a=8'h3C, b=8'h7C (chunk 3 mismatch) -> rsp1_eq=0 in T+5.
- Both requesters valid continuously from reset with equal operands -> grants alternate 0,1,0,1; each response 5 cycles after its handshake; ready never high for both in one cycle.
- Both valid, req0 a=8'h00/b=8'h00, req1 a=8'hFF/b=8'hFE -> req0 served first (rsp0_eq=1), then req1 (rsp1_eq=0); data changes on the waiting requester before its ready are not sampled.
- Assert reset for 1 cycle during CMP (index=2) -> outputs 0 immediately; no rsp pulse; next request completes normally with correct latency; WIDTH=2 build: a=2'b10, b=2'b10 -> rsp at T+2, eq=1.

Source files
------------

// File: rtl/eq_share_ctrl.sv
// ============================================================================
// eq_share_ctrl
// ----------------------------------------------------------------------------
// Purpose:
//   Two requesters share one 2-bit equality slice (two 1-bit XNOR cells
//   ANDed). A granted operand pair is captured internally and compared
//   serially, 2 bits per cycle, least-significant chunk first. The compare
//   stops on the first mismatching chunk. The result is returned as a
//   single-cycle pulse to the requester that won arbitration.
//   Arbitration is round-robin on ties, based on the last requester served.
//
// Parameters:
//   WIDTH       operand width in bits (even, >= 2); CHUNKS = WIDTH/2
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   req0_valid  requester 0 presents an operand pair
//   req0_ready  requester 0 pair accepted this cycle
//   req0_a/b    requester 0 operands
//   req1_valid  requester 1 presents an operand pair
//   req1_ready  requester 1 pair accepted this cycle
//   req1_a/b    requester 1 operands
//   rsp0_valid  one-cycle result pulse for requester 0
//   rsp0_eq     1 = operands equal, qualified by rsp0_valid
//   rsp1_valid  one-cycle result pulse for requester 1
//   rsp1_eq     1 = operands equal, qualified by rsp1_valid
//   busy        high while comparing or presenting the result
//   grant_id    requester owning the current or last transaction
// ============================================================================
module eq_share_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,

    output logic             rsp0_valid,
    output logic             rsp0_eq,
    output logic             rsp1_valid,
    output logic             rsp1_eq,

    output logic             busy,
    output logic             grant_id
);

    localparam int CHUNKS = WIDTH / 2;
    // Keep the index at least one bit wide so WIDTH=2 still elaborates.
    localparam int IDX_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [IDX_W-1:0] idx;
    logic             result;
    logic             last_grant;
    logic             grant_reg;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;

    logic             winner;
    logic             accept0;
    logic             accept1;

    logic [CHUNKS-1:0][1:0] a_chunks;
    logic [CHUNKS-1:0][1:0] b_chunks;
    logic [1:0]       chunk_a;
    logic [1:0]       chunk_b;
    logic             eq_bit0;
    logic             eq_bit1;
    logic             eq_chunk;
    logic             last_chunk;

    // ------------------------------------------------------------------------
    // Arbitration. A lone requester always wins; on a tie the requester that
    // was not served last wins. last_grant resets to 1 so requester 0 takes
    // the first tie.
    // ------------------------------------------------------------------------
    always_comb begin
        winner = 1'b0;
        if (req0_valid && req1_valid) begin
            winner = ~last_grant;
        end else if (req1_valid) begin
            winner = 1'b1;
        end
    end

    assign accept0 = (state == IDLE) && req0_valid && (winner == 1'b0);
    assign accept1 = (state == IDLE) && req1_valid && (winner == 1'b1);

    // ------------------------------------------------------------------------
    // Shared 2-bit equality slice. The captured operands are viewed as an
    // array of 2-bit chunks and the current chunk is muxed into the slice.
    // ------------------------------------------------------------------------
    assign a_chunks   = op_a;
    assign b_chunks   = op_b;
    assign chunk_a    = a_chunks[idx];
    assign chunk_b    = b_chunks[idx];
    assign eq_bit0    = ~(chunk_a[0] ^ chunk_b[0]);
    assign eq_bit1    = ~(chunk_a[1] ^ chunk_b[1]);
    assign eq_chunk   = eq_bit0 & eq_bit1;
    assign last_chunk = (idx == LAST_IDX);

    // ------------------------------------------------------------------------
    // FSM state register.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state logic. CMP leaves early on the first mismatch, or after
    // the last chunk matched. DONE always lasts exactly one cycle.
    // ------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept0 || accept1) begin
                    state_next = CMP;
                end
            end
            CMP: begin
                if (!eq_chunk || last_chunk) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM outputs. Everything is decoded from registered state so the
    // response pulse has no combinational path from the requester inputs.
    // ------------------------------------------------------------------------
    always_comb begin
        req0_ready = accept0;
        req1_ready = accept1;
        busy       = (state == CMP) || (state == DONE);
        grant_id   = grant_reg;
        rsp0_valid = (state == DONE) && (grant_reg == 1'b0);
        rsp1_valid = (state == DONE) && (grant_reg == 1'b1);
        rsp0_eq    = rsp0_valid && result;
        rsp1_eq    = rsp1_valid && result;
    end

    // ------------------------------------------------------------------------
    // Control datapath: chunk index, result, owner of the transaction and
    // the round-robin history. last_grant only moves in DONE, so an aborted
    // transaction does not disturb the fairness order.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx        <= '0;
            result     <= 1'b0;
            last_grant <= 1'b1;
            grant_reg  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept0) begin
                        grant_reg <= 1'b0;
                        idx       <= '0;
                    end else if (accept1) begin
                        grant_reg <= 1'b1;
                        idx       <= '0;
                    end
                end
                CMP: begin
                    if (!eq_chunk) begin
                        result <= 1'b0;
                    end else if (last_chunk) begin
                        result <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    last_grant <= grant_reg;
                end
                default: begin
                    idx <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Operand holding registers. Their contents are meaningless outside a
    // transaction, so they carry no reset and only load on a handshake.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (accept0) begin
            op_a <= req0_a;
            op_b <= req0_b;
        end else if (accept1) begin
            op_a <= req1_a;
            op_b <= req1_b;
        end
    end

endmodule

// File: tb/tb_eq_share_ctrl.sv
// ============================================================================
// tb_eq_share_ctrl
// ----------------------------------------------------------------------------
// Bench for eq_share_ctrl (WIDTH=8 main instance plus a WIDTH=2 instance).
// A reference model predicts ready/busy/grant every cycle and, on each
// predicted handshake, pushes the expected response (equality and arrival
// cycle) into a per-requester queue. An independent monitor pops and checks
// whenever a response pulse appears.
// ============================================================================
module tb_eq_share_ctrl;

    localparam int W      = 8;
    localparam int CHUNKS = W / 2;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;

    logic       req0_valid = 1'b0;
    logic       req1_valid = 1'b0;
    logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic       req0_ready, req1_ready;
    logic       rsp0_valid, rsp0_eq, rsp1_valid, rsp1_eq;
    logic       busy, grant_id;

    logic       d2_req0_valid = 1'b0;
    logic       d2_req1_valid = 1'b0;
    logic [1:0] d2_req0_a = '0, d2_req0_b = '0, d2_req1_a = '0, d2_req1_b = '0;
    logic       d2_req0_ready, d2_req1_ready;
    logic       d2_rsp0_valid, d2_rsp0_eq, d2_rsp1_valid, d2_rsp1_eq;
    logic       d2_busy, d2_grant_id;

    eq_share_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp0_valid (rsp0_valid),
        .rsp0_eq    (rsp0_eq),
        .rsp1_valid (rsp1_valid),
        .rsp1_eq    (rsp1_eq),
        .busy       (busy),
        .grant_id   (grant_id)
    );

    eq_share_ctrl #(.WIDTH(2)) dut2 (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (d2_req0_valid),
        .req0_ready (d2_req0_ready),
        .req0_a     (d2_req0_a),
        .req0_b     (d2_req0_b),
        .req1_valid (d2_req1_valid),
        .req1_ready (d2_req1_ready),
        .req1_a     (d2_req1_a),
        .req1_b     (d2_req1_b),
        .rsp0_valid (d2_rsp0_valid),
        .rsp0_eq    (d2_rsp0_eq),
        .rsp1_valid (d2_rsp1_valid),
        .rsp1_eq    (d2_rsp1_eq),
        .busy       (d2_busy),
        .grant_id   (d2_grant_id)
    );

    always #5 clk = ~clk;

    // Cycle number: incremented on every rising edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int   due;
        logic eq;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int   free_cycle = 0;
    logic m_last     = 1'b1;
    logic m_grant    = 1'b0;

    // Requester drive values and per-cycle handshake outcome.
    logic       dv0 = 1'b0, dv1 = 1'b0;
    logic [7:0] da0 = '0, db0 = '0, da1 = '0, db1 = '0;
    logic       acc0 = 1'b0, acc1 = 1'b0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Response latency from the compare rules: the first mismatching chunk j
    // answers after j+2 cycles, a full match after CHUNKS+1 cycles.
    function automatic int expLat(input logic [7:0] a, input logic [7:0] b);
        for (int k = 0; k < CHUNKS; k++) begin
            if (((a >> (2 * k)) & 8'h03) != ((b >> (2 * k)) & 8'h03)) return k + 2;
        end
        return CHUNKS + 1;
    endfunction

    task automatic pushExp(input int n, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int   lat;
        lat   = expLat(a, b);
        e.due = cyc + lat;
        e.eq  = (a == b);
        if (n == 0) q0.push_back(e);
        else        q1.push_back(e);
        free_cycle = cyc + lat + 1;
        m_grant    = n[0];
        m_last     = n[0];
    endtask

    // One clock cycle: drive requester inputs after the falling edge, then
    // check the combinational handshake against the model and record the
    // predicted transfer for the coming rising edge.
    task automatic applyStimulus();
        logic free, win, er0, er1;
        @(negedge clk);
        req0_valid = dv0; req0_a = da0; req0_b = db0;
        req1_valid = dv1; req1_a = da1; req1_b = db1;
        #1;
        free = (cyc >= free_cycle);
        if (dv0 && dv1) win = ~m_last;
        else            win = dv1;
        er0 = free && dv0 && !win;
        er1 = free && dv1 && win;
        checkOutput("req0_ready", req0_ready, er0);
        checkOutput("req1_ready", req1_ready, er1);
        checkOutput("busy", busy, !free);
        checkOutput("grant_id", grant_id, m_grant);
        acc0 = er0;
        acc1 = er1;
        if (er0) pushExp(0, da0, db0);
        if (er1) pushExp(1, da1, db1);
    endtask

    task automatic modelReset();
        q0.delete();
        q1.delete();
        free_cycle = 0;
        m_last     = 1'b1;
        m_grant    = 1'b0;
    endtask

    // Asserts reset away from the clock edges for one rising edge.
    task automatic pulseReset();
        dv0 = 1'b0; dv1 = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        checkOutput("reset busy", busy, 0);
        checkOutput("reset grant_id", grant_id, 0);
        checkOutput("reset rsp0_valid", rsp0_valid, 0);
        checkOutput("reset rsp1_valid", rsp1_valid, 0);
        checkOutput("reset req0_ready", req0_ready, 0);
        checkOutput("reset req1_ready", req1_ready, 0);
        modelReset();
        @(negedge clk);
        #3 reset = 1'b0;
    endtask

    task automatic issueOne(input int n, input logic [7:0] a, input logic [7:0] b, output int t);
        logic got;
        got = 1'b0;
        t   = -1;
        if (n == 0) begin dv0 = 1'b1; da0 = a; db0 = b; end
        else        begin dv1 = 1'b1; da1 = a; db1 = b; end
        for (int k = 0; k < 40 && !got; k++) begin
            applyStimulus();
            got = (n == 0) ? acc0 : acc1;
            if (got) t = cyc;
        end
        checkOutput("request accepted", got, 1);
        if (n == 0) dv0 = 1'b0;
        else        dv1 = 1'b0;
    endtask

    task automatic waitIdle();
        for (int k = 0; k < 40; k++) begin
            if (q0.size() == 0 && q1.size() == 0 && cyc >= free_cycle) break;
            applyStimulus();
        end
    endtask

    task automatic genPair(output logic [7:0] a, output logic [7:0] b);
        a = 8'($urandom);
        b = a;
        if ($urandom_range(0, 2) != 0) b = b ^ (8'h01 << $urandom_range(0, 7));
    endtask

    task automatic checkRsp(input int n);
        logic v, e;
        exp_t x;
        v = (n == 0) ? rsp0_valid : rsp1_valid;
        e = (n == 0) ? rsp0_eq    : rsp1_eq;
        if (!v) begin
            checkOutput($sformatf("rsp%0d_eq while idle", n), e, 0);
            if (n == 0 && q0.size() > 0 && q0[0].due < cyc) begin
                checkOutput("rsp0_valid missing", v, 1);
                void'(q0.pop_front());
            end
            if (n == 1 && q1.size() > 0 && q1[0].due < cyc) begin
                checkOutput("rsp1_valid missing", v, 1);
                void'(q1.pop_front());
            end
        end else if ((n == 0 && q0.size() == 0) || (n == 1 && q1.size() == 0)) begin
            checkOutput($sformatf("rsp%0d_valid unexpected", n), v, 0);
        end else begin
            x = (n == 0) ? q0.pop_front() : q1.pop_front();
            checkOutput($sformatf("rsp%0d_eq", n), e, x.eq);
            checkOutput($sformatf("rsp%0d latency cycle", n), cyc, x.due);
        end
    endtask

    // Response monitor, decoupled from stimulus.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            checkRsp(0);
            checkRsp(1);
        end
    end

    task automatic d2Check(input logic [1:0] a, input logic [1:0] b);
        int   t;
        logic found;
        @(negedge clk);
        d2_req0_valid = 1'b1; d2_req0_a = a; d2_req0_b = b;
        #1;
        checkOutput("w2 req0_ready", d2_req0_ready, 1);
        t     = cyc;
        found = 1'b0;
        @(negedge clk);
        d2_req0_valid = 1'b0;
        d2_req0_a = ~a;
        for (int k = 0; k < 6 && !found; k++) begin
            #1;
            checkOutput("w2 rsp1_valid", d2_rsp1_valid, 0);
            if (d2_rsp0_valid) begin
                found = 1'b1;
                checkOutput("w2 rsp0 latency cycle", cyc, t + 2);
                checkOutput("w2 rsp0_eq", d2_rsp0_eq, (a == b));
            end else begin
                @(negedge clk);
            end
        end
        checkOutput("w2 rsp0 seen", found, 1);
    endtask

    // ------------------------------------------------------------------------
    // Main sequence.
    // ------------------------------------------------------------------------
    initial begin
        int   t;
        int   order[$];
        logic [7:0] a, b;

        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset busy", busy, 0);
        checkOutput("reset grant_id", grant_id, 0);
        checkOutput("reset rsp0_valid", rsp0_valid, 0);
        checkOutput("reset rsp1_valid", rsp1_valid, 0);
        checkOutput("reset w2 busy", d2_busy, 0);
        reset = 1'b0;

        $display("[TB] full match on requester 0");
        issueOne(0, 8'hA5, 8'hA5, t);
        waitIdle();

        $display("[TB] requester 1 mismatch at chunk 0 and chunk 3");
        issueOne(1, 8'h3C, 8'h3D, t);
        waitIdle();
        issueOne(1, 8'h3C, 8'h7C, t);
        waitIdle();

        $display("[TB] both requesters continuously valid");
        @(negedge clk);
        pulseReset();
        dv0 = 1'b1; dv1 = 1'b1;
        genPair(a, b); da0 = a; db0 = a;
        genPair(a, b); da1 = a; db1 = a;
        for (int k = 0; k < 60 && order.size() < 4; k++) begin
            applyStimulus();
            if (acc0) begin order.push_back(0); da0 = 8'($urandom); db0 = da0; end
            if (acc1) begin order.push_back(1); da1 = 8'($urandom); db1 = da1; end
        end
        checkOutput("alternation length", order.size(), 4);
        for (int k = 0; k < order.size(); k++) checkOutput($sformatf("alternation grant %0d", k), order[k], k % 2);
        dv0 = 1'b0; dv1 = 1'b0;
        waitIdle();

        $display("[TB] tie with different operands");
        order.delete();
        dv0 = 1'b1; da0 = 8'h00; db0 = 8'h00;
        dv1 = 1'b1; da1 = 8'hFF; db1 = 8'hFE;
        for (int k = 0; k < 40 && order.size() < 2; k++) begin
            applyStimulus();
            if (acc0) begin order.push_back(0); dv0 = 1'b0; end
            if (acc1) begin order.push_back(1); dv1 = 1'b0; end
        end
        checkOutput("tie served count", order.size(), 2);
        if (order.size() > 0) checkOutput("tie first winner", order[0], 0);
        waitIdle();

        $display("[TB] reset during compare");
        issueOne(1, 8'hB7, 8'hB7, t);
        while (cyc < t + 3) applyStimulus();
        pulseReset();
        repeat (8) applyStimulus();
        issueOne(1, 8'h5A, 8'h5A, t);
        waitIdle();
        issueOne(0, 8'h12, 8'h92, t);
        waitIdle();

        $display("[TB] WIDTH=2 instance");
        d2Check(2'b10, 2'b10);
        d2Check(2'b10, 2'b11);

        $display("[TB] randomized traffic");
        for (int k = 0; k < 400; k++) begin
            if (!dv0) begin
                if ($urandom_range(0, 2) == 0) begin genPair(a, b); dv0 = 1'b1; da0 = a; db0 = b; end
            end else if ($urandom_range(0, 7) == 0) begin
                genPair(a, b); da0 = a; db0 = b;
            end else if ($urandom_range(0, 15) == 0) begin
                dv0 = 1'b0;
            end
            if (!dv1) begin
                if ($urandom_range(0, 2) == 0) begin genPair(a, b); dv1 = 1'b1; da1 = a; db1 = b; end
            end else if ($urandom_range(0, 7) == 0) begin
                genPair(a, b); da1 = a; db1 = b;
            end else if ($urandom_range(0, 15) == 0) begin
                dv1 = 1'b0;
            end
            applyStimulus();
            if (acc0) begin dv0 = $urandom_range(0, 1) == 1; genPair(a, b); da0 = a; db0 = b; end
            if (acc1) begin dv1 = $urandom_range(0, 1) == 1; genPair(a, b); da1 = a; db1 = b; end
        end
        dv0 = 1'b0; dv1 = 1'b0;
        waitIdle();
        applyStimulus();
        applyStimulus();
        checkOutput("outstanding responses", q0.size() + q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
